reg_file_sb: RTL and testbench

Parametrised successor to the pipeline's integer register file.
- Generalised storage: configurable width, depth and optional hardwired-zero register.
- Write-through read bypass.
- Per-register pending-write scoreboard, so the decode stage can detect RAW hazards.
- Sequenced post-reset clear, one entry per cycle, with a ready flag that gates issue.

---
 rtl/reg_file_sb_if.sv | 37 +++
 rtl/reg_file_sb.sv | 143 ++++++++++++++
 tb/tb_reg_file_sb.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: writeback, issue and dual read ports plus the
// ready flag. The pipeline side uses master and the register file uses slave.
interface reg_file_sb_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              ready;
  logic              reg_write;
  logic [ADDR_W-1:0] reg_write_dest;
  logic [DATA_W-1:0] reg_write_data;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_dest;
  logic [ADDR_W-1:0] reg_read_addr_1;
  logic [ADDR_W-1:0] reg_read_addr_2;
  logic [DATA_W-1:0] reg_read_data_1;
  logic [DATA_W-1:0] reg_read_data_2;
  logic              busy_1;
  logic              busy_2;

  modport master (
    input  ready,
    output reg_write, reg_write_dest, reg_write_data,
    output issue_valid, issue_dest,
    output reg_read_addr_1, reg_read_addr_2,
    input  reg_read_data_1, reg_read_data_2,
    input  busy_1, busy_2
  );

  modport slave (
    output ready,
    input  reg_write, reg_write_dest, reg_write_data,
    input  issue_valid, issue_dest,
    input  reg_read_addr_1, reg_read_addr_2,
    output reg_read_data_1, reg_read_data_2,
    output busy_1, busy_2
  );
endinterface

// File: rtl/reg_file_sb.sv
// Parametrised integer register file with write-through bypass, a per-register
// pending-write scoreboard and a sequenced post-reset clear gated by ready.
module reg_file_sb #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_sb_if.slave  bus
);

  localparam logic [0:0]        ST_INIT    = 1'b0;
  localparam logic [0:0]        ST_READY   = 1'b1;
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

  // An address is usable when it is implemented and not the hardwired zero.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    addr_ok = ({1'b0, a} < NUM_REGS_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [0:0]        state_reg, state_next;
  logic [ADDR_W-1:0] clr_idx_reg, clr_idx_next;
  logic              ready_reg, ready_next;
  logic [NUM_REGS-1:0] pending_reg, pending_next;

  logic [DATA_W-1:0] mem [NUM_REGS];

  logic              is_init;
  logic              wr_legal;
  logic              iss_legal;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign is_init   = (state_reg == ST_INIT);
  assign wr_legal  = ready_reg && bus.reg_write   && addr_ok(bus.reg_write_dest);
  assign iss_legal = ready_reg && bus.issue_valid && addr_ok(bus.issue_dest);

  // Control sequencer: walk clr_idx across every entry, then open the file.
  always_comb begin
    state_next   = state_reg;
    clr_idx_next = clr_idx_reg;
    ready_next   = ready_reg;
    if (is_init) begin
      clr_idx_next = clr_idx_reg + 1'b1;
      if (clr_idx_reg == LAST_IDX) begin
        state_next = ST_READY;
        ready_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_INIT;
      clr_idx_reg <= '0;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clr_idx_reg <= clr_idx_next;
      ready_reg   <= ready_next;
    end
  end

  // Single write port shared by the clear walker and the writeback path.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.reg_write_dest;
    mem_wdata = bus.reg_write_data;
    if (is_init) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx_reg;
      mem_wdata = '0;
    end else if (wr_legal) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Scoreboard: a new issue to the same index overrides a retiring write.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
      if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
        assign pending_next[gi] = 1'b0;
      end else begin : g_bit
        assign pending_next[gi] =
            (iss_legal && (bus.issue_dest == IDX)) ||
            (pending_reg[gi] && !(wr_legal && (bus.reg_write_dest == IDX)));
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  logic [ADDR_W-1:0] rd_addr [2];
  assign rd_addr[0] = bus.reg_read_addr_1;
  assign rd_addr[1] = bus.reg_read_addr_2;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic              hit;
      logic              valid;
      logic [DATA_W-1:0] data;
      logic              busy;

      assign hit   = wr_legal && (bus.reg_write_dest == rd_addr[gi]);
      assign valid = ready_reg && addr_ok(rd_addr[gi]);

      always_comb begin
        data = '0;
        if (valid) begin
          data = hit ? bus.reg_write_data : mem[rd_addr[gi]];
        end
      end

      // A retiring write to this register resolves the hazard this cycle.
      assign busy = valid && pending_reg[rd_addr[gi]] && !hit;
    end
  endgenerate

  assign bus.ready           = ready_reg;
  assign bus.reg_read_data_1 = g_rd[0].data;
  assign bus.reg_read_data_2 = g_rd[1].data;
  assign bus.busy_1          = g_rd[0].busy;
  assign bus.busy_2          = g_rd[1].busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomised and directed check of two reg_file_sb configurations (64x32 and
// 32-bit x12 with 4-bit addresses) against an array-based reference model.
module tb_reg_file_sb;

  logic clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;
  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(64), .ADDR_W(5)) ifa ();
  reg_file_sb_if #(.DATA_W(32), .ADDR_W(4)) ifb ();

  reg_file_sb #(.DATA_W(64), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1))
    dut_a (.clk(clk), .rst_n(rst_n_a), .bus(ifa));
  reg_file_sb #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(12), .ZERO_REG(1))
    dut_b (.clk(clk), .rst_n(rst_n_b), .bus(ifb));

  typedef struct {
    bit          rn;
    bit          we;
    int          dest;
    logic [63:0] wd;
    bit          iv;
    int          idest;
    int          a1;
    int          a2;
  } stim_t;

  localparam int          NR   [2] = '{32, 12};
  localparam int          AMAX [2] = '{32, 16};
  localparam logic [63:0] MASK [2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF};

  stim_t       s [2];
  logic [63:0] m_mem  [2][32];
  bit          m_pend [2][32];
  bit          m_rdy  [2];
  int          m_cnt  [2];

  logic [63:0] last_o1 [2];
  logic [63:0] last_o2 [2];
  logic        last_b1 [2];
  logic        last_b2 [2];
  logic        last_rdy[2];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input int k, input int a);
    return (a < NR[k]) && (a != 0);
  endfunction

  function automatic bit wr_hits(input int k, input int a);
    return m_rdy[k] && s[k].we && legal(k, s[k].dest) && (s[k].dest == a);
  endfunction

  function automatic logic [63:0] exp_rd(input int k, input int a);
    if (!m_rdy[k] || !legal(k, a)) return 64'h0;
    if (wr_hits(k, a))             return s[k].wd & MASK[k];
    return m_mem[k][a];
  endfunction

  function automatic bit exp_busy(input int k, input int a);
    return m_rdy[k] && legal(k, a) && m_pend[k][a] && !wr_hits(k, a);
  endfunction

  // Reference behaviour at a rising edge, from the block's architectural rules.
  task automatic model_edge(input int k);
    if (!s[k].rn) begin
      m_rdy[k] = 1'b0;
      m_cnt[k] = 0;
      for (int i = 0; i < 32; i++) m_pend[k][i] = 1'b0;
    end else if (!m_rdy[k]) begin
      m_cnt[k]++;
      if (m_cnt[k] == NR[k]) begin
        m_rdy[k] = 1'b1;
        for (int i = 0; i < 32; i++) m_mem[k][i] = 64'h0;
      end
    end else begin
      if (s[k].we && legal(k, s[k].dest)) begin
        m_mem[k][s[k].dest]  = s[k].wd & MASK[k];
        m_pend[k][s[k].dest] = 1'b0;
      end
      if (s[k].iv && legal(k, s[k].idest)) m_pend[k][s[k].idest] = 1'b1;
    end
  endtask

  task automatic idle(input int k);
    s[k] = '{1'b1, 1'b0, 0, 64'h0, 1'b0, 0, 0, 0};
  endtask

  task automatic rnd(input int k);
    s[k].rn    = 1'b1;
    s[k].we    = ($urandom_range(0, 1) == 1);
    s[k].dest  = $urandom_range(0, AMAX[k] - 1);
    s[k].wd    = {$urandom, $urandom} & MASK[k];
    s[k].iv    = ($urandom_range(0, 2) == 0);
    s[k].idest = $urandom_range(0, AMAX[k] - 1);
    s[k].a1    = ($urandom_range(0, 3) == 0) ? s[k].dest : $urandom_range(0, AMAX[k] - 1);
    s[k].a2    = ($urandom_range(0, 3) == 0) ? s[k].idest : $urandom_range(0, AMAX[k] - 1);
  endtask

  // One clock: drive at negedge, check outputs before the edge, advance model.
  task automatic step();
    logic [63:0] o1, o2;
    logic        ob1, ob2, ordy;
    string       nm;
    @(negedge clk);
    rst_n_a             = s[0].rn;
    ifa.reg_write       = s[0].we;
    ifa.reg_write_dest  = 5'(s[0].dest);
    ifa.reg_write_data  = s[0].wd;
    ifa.issue_valid     = s[0].iv;
    ifa.issue_dest      = 5'(s[0].idest);
    ifa.reg_read_addr_1 = 5'(s[0].a1);
    ifa.reg_read_addr_2 = 5'(s[0].a2);
    rst_n_b             = s[1].rn;
    ifb.reg_write       = s[1].we;
    ifb.reg_write_dest  = 4'(s[1].dest);
    ifb.reg_write_data  = 32'(s[1].wd);
    ifb.issue_valid     = s[1].iv;
    ifb.issue_dest      = 4'(s[1].idest);
    ifb.reg_read_addr_1 = 4'(s[1].a1);
    ifb.reg_read_addr_2 = 4'(s[1].a2);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        o1 = ifa.reg_read_data_1; o2 = ifa.reg_read_data_2;
        ob1 = ifa.busy_1; ob2 = ifa.busy_2; ordy = ifa.ready;
      end else begin
        o1 = {32'h0, ifb.reg_read_data_1}; o2 = {32'h0, ifb.reg_read_data_2};
        ob1 = ifb.busy_1; ob2 = ifb.busy_2; ordy = ifb.ready;
      end
      nm = $sformatf("%s c%0d", (k == 0) ? "A" : "B", cyc);
      chk({nm, " ready"}, {63'h0, ordy}, {63'h0, m_rdy[k]});
      chk($sformatf("%s rd1[%0d]", nm, s[k].a1), o1, exp_rd(k, s[k].a1));
      chk($sformatf("%s rd2[%0d]", nm, s[k].a2), o2, exp_rd(k, s[k].a2));
      chk($sformatf("%s busy1[%0d]", nm, s[k].a1), {63'h0, ob1}, {63'h0, exp_busy(k, s[k].a1)});
      chk($sformatf("%s busy2[%0d]", nm, s[k].a2), {63'h0, ob2}, {63'h0, exp_busy(k, s[k].a2)});
      last_o1[k] = o1; last_o2[k] = o2;
      last_b1[k] = ob1; last_b2[k] = ob2; last_rdy[k] = ordy;
    end
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    cyc++;
  endtask

  initial begin
    int ra, rb;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    ifa.reg_write = 1'b0; ifa.reg_write_dest = '0; ifa.reg_write_data = '0;
    ifa.issue_valid = 1'b0; ifa.issue_dest = '0;
    ifa.reg_read_addr_1 = '0; ifa.reg_read_addr_2 = '0;
    ifb.reg_write = 1'b0; ifb.reg_write_dest = '0; ifb.reg_write_data = '0;
    ifb.issue_valid = 1'b0; ifb.issue_dest = '0;
    ifb.reg_read_addr_1 = '0; ifb.reg_read_addr_2 = '0;
    for (int k = 0; k < 2; k++) begin
      m_rdy[k] = 1'b0; m_cnt[k] = 0;
      for (int i = 0; i < 32; i++) begin m_mem[k][i] = 64'h0; m_pend[k][i] = 1'b0; end
    end
    repeat (2) @(posedge clk);

    // Reset held, then release with writes/issues to reg 3 that must be lost.
    idle(0); idle(1); s[0].rn = 1'b0; s[1].rn = 1'b0;
    step();
    ra = -1; rb = -1;
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (i < NR[k]) s[k] = '{1'b1, 1'b1, 3, 64'hAAAA_5555_AAAA_5555 & MASK[k], 1'b1, 3, 3, 3};
        else           s[k] = '{1'b1, 1'b0, 0, 64'h0, 1'b0, 0, 3, 3};
      end
      step();
      if (last_rdy[0] && ra < 0) ra = i;
      if (last_rdy[1] && rb < 0) rb = i;
    end
    chk("A ready latency", 64'(ra), 64'd32);
    chk("B ready latency", 64'(rb), 64'd12);
    chk("A init write lost", last_o1[0], 64'h0);
    chk("B init write lost", last_o1[1], 64'h0);
    chk("A init issue lost", {63'h0, last_b1[0]}, 64'h0);

    // Hardwired zero register.
    idle(1);
    s[0] = '{1'b1, 1'b1, 0, 64'hDEAD, 1'b0, 0, 0, 0}; step();
    chk("A zero bypass", last_o1[0], 64'h0);
    s[0] = '{1'b1, 1'b0, 0, 64'h0, 1'b1, 0, 0, 0}; step();
    idle(0); step();
    chk("A zero rd", last_o1[0], 64'h0);
    chk("A zero busy", {63'h0, last_b1[0]}, 64'h0);

    // Write-through bypass then stored read.
    s[0] = '{1'b1, 1'b1, 7, 64'h1234_5678_9ABC_DEF0, 1'b0, 0, 7, 7}; step();
    chk("A bypass same cycle", last_o1[0], 64'h1234_5678_9ABC_DEF0);
    idle(0); s[0].a1 = 7; step();
    chk("A stored next cycle", last_o1[0], 64'h1234_5678_9ABC_DEF0);

    // Scoreboard set / clear / simultaneous set-wins.
    s[0] = '{1'b1, 1'b0, 0, 64'h0, 1'b1, 5, 5, 5}; step();
    chk("A busy not same cycle", {63'h0, last_b1[0]}, 64'h0);
    idle(0); s[0].a1 = 5; s[0].a2 = 5; step();
    chk("A busy after issue p1", {63'h0, last_b1[0]}, 64'h1);
    chk("A busy after issue p2", {63'h0, last_b2[0]}, 64'h1);
    s[0] = '{1'b1, 1'b1, 5, 64'h55, 1'b0, 0, 5, 5}; step();
    chk("A busy writeback", {63'h0, last_b1[0]}, 64'h0);
    idle(0); s[0].a1 = 5; step();
    chk("A busy stays clear", {63'h0, last_b1[0]}, 64'h0);
    s[0] = '{1'b1, 1'b1, 5, 64'h66, 1'b1, 5, 5, 5}; step();
    idle(0); s[0].a1 = 5; step();
    chk("A set wins", {63'h0, last_b1[0]}, 64'h1);

    // Small configuration: out-of-range write, all-ones round trip.
    idle(0);
    s[1] = '{1'b1, 1'b1, 13, 64'h1357_2468, 1'b1, 13, 13, 13}; step();
    chk("B oor bypass", last_o1[1], 64'h0);
    idle(1); s[1].a1 = 13; step();
    chk("B oor rd", last_o1[1], 64'h0);
    chk("B oor busy", {63'h0, last_b1[1]}, 64'h0);
    s[1] = '{1'b1, 1'b1, 11, 64'hFFFF_FFFF, 1'b0, 0, 0, 11}; step();
    chk("B max bypass", last_o2[1], 64'hFFFF_FFFF);
    idle(1); s[1].a2 = 11; step();
    chk("B max stored", last_o2[1], 64'hFFFF_FFFF);

    for (int i = 0; i < 400; i++) begin rnd(0); rnd(1); step(); end

    // Mid-sequence reset of A: restart after 10 cleared entries.
    idle(1); idle(0); s[0].rn = 1'b0; step();
    for (int i = 0; i < 10; i++) begin idle(0); s[0].a1 = i + 1; step(); end
    idle(0); s[0].rn = 1'b0; step();
    ra = -1;
    for (int i = 0; i < 40; i++) begin idle(0); step(); if (last_rdy[0] && ra < 0) ra = i; end
    chk("A restart latency", 64'(ra), 64'd32);
    for (int i = 0; i < 16; i++) begin
      idle(0); s[0].a1 = 2 * i; s[0].a2 = 2 * i + 1; step();
      chk($sformatf("A pend cleared %0d", 2 * i), {63'h0, last_b1[0] | last_b2[0]}, 64'h0);
    end

    for (int i = 0; i < 200; i++) begin rnd(0); rnd(1); step(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
